fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// holds the returned word for decode, handles branch redirects (including
// squashing an in-flight response) and stops permanently on a halt opcode.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | one cycle after reset, no request
// FETCH  | request outstanding at req_addr, waiting for imem_valid
// HOLD   | instruction valid on inst/pc, waiting for decode or a branch
// SQUASH | stale request in flight; drop its data, then fetch redirect_pc
// HALT   | halt opcode seen; frozen until reset
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        hlt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_HOLD   = 3'd2,
    S_SQUASH = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] redirect_q, redirect_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] pc_q, pc_d;
  logic        hlt_q, hlt_d;
  logic [15:0] br_even;

  // Branch targets are halfword aligned; the low bit is simply dropped.
  assign br_even = br_target & 16'hFFFE;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      req_addr_q <= RESET_PC;
      redirect_q <= 16'h0000;
      inst_q     <= 16'h0000;
      pc_q       <= 16'h0000;
      hlt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      redirect_q <= redirect_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      hlt_q      <= hlt_d;
    end
  end

  // Next-state and next-datapath decisions.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    redirect_d = redirect_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    hlt_d      = hlt_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (br_taken) begin
          if (imem_valid) begin
            req_addr_d = br_even;
          end else begin
            redirect_d = br_even;
            state_d    = S_SQUASH;
          end
        end else if (imem_valid) begin
          pc_d = req_addr_q;
          if (imem_rdata[15:12] == HALT_OPCODE) begin
            hlt_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            inst_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_SQUASH: begin
        // Latest redirect wins, even when it lands with the stale response.
        if (br_taken) redirect_d = br_even;
        if (imem_valid) begin
          req_addr_d = br_taken ? br_even : redirect_q;
          state_d    = S_FETCH;
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          req_addr_d = br_even;
          state_d    = S_FETCH;
        end else if (inst_ready) begin
          req_addr_d = pc_q + 16'd2;
          state_d    = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    imem_req   = (state_q == S_FETCH) || (state_q == S_SQUASH);
    inst_valid = (state_q == S_HOLD);
    imem_addr  = req_addr_q;
    inst       = inst_q;
    pc         = pc_q;
    pc_plus2   = pc_q + 16'd2;
    hlt        = hlt_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural model compared every cycle,
// plus literal expectations at the scenario checkpoints.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        br_taken;
  logic [15:0] br_target;
  logic        inst_ready;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        hlt;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .inst_ready (inst_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .hlt        (hlt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetcher is doing, described as flags.
  logic        started = 1'b0;
  logic        m_idle, m_have, m_drop, m_hlt;
  logic [15:0] m_addr, m_redir, m_inst, m_pc;

  always @(posedge clk) begin
    if (!rst) begin
      started <= 1'b1;
      m_idle  <= 1'b1;
      m_have  <= 1'b0;
      m_drop  <= 1'b0;
      m_hlt   <= 1'b0;
      m_addr  <= 16'h0000;
      m_redir <= 16'h0000;
      m_inst  <= 16'h0000;
      m_pc    <= 16'h0000;
    end else if (started && !m_hlt) begin
      if (m_idle) begin
        m_idle <= 1'b0;
      end else if (m_have) begin
        if (br_taken) begin
          m_have <= 1'b0;
          m_addr <= {br_target[15:1], 1'b0};
        end else if (inst_ready) begin
          m_have <= 1'b0;
          m_addr <= m_pc + 16'd2;
        end
      end else if (m_drop) begin
        if (br_taken) m_redir <= {br_target[15:1], 1'b0};
        if (imem_valid) begin
          m_drop <= 1'b0;
          m_addr <= br_taken ? {br_target[15:1], 1'b0} : m_redir;
        end
      end else begin
        if (br_taken) begin
          if (imem_valid) m_addr <= {br_target[15:1], 1'b0};
          else begin
            m_drop  <= 1'b1;
            m_redir <= {br_target[15:1], 1'b0};
          end
        end else if (imem_valid) begin
          m_pc <= m_addr;
          if (imem_rdata[15:12] == 4'hF) m_hlt <= 1'b1;
          else begin
            m_have <= 1'b1;
            m_inst <= imem_rdata;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("req",      {15'd0, imem_req},   {15'd0, !m_idle && !m_have && !m_hlt});
      chk("addr",     imem_addr,           m_addr);
      chk("ivalid",   {15'd0, inst_valid}, {15'd0, m_have});
      chk("inst",     inst,                m_inst);
      chk("pc",       pc,                  m_pc);
      chk("pc_plus2", pc_plus2,            m_pc + 16'd2);
      chk("hlt",      {15'd0, hlt},        {15'd0, m_hlt});
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [15:0] rd,
                     input logic b, input logic [15:0] t, input logic rdy);
    @(negedge clk);
    rst        = r;
    imem_valid = v;
    imem_rdata = rd;
    br_taken   = b;
    br_target  = t;
    inst_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    rst = 1'b0; imem_valid = 1'b0; imem_rdata = 16'h0; br_taken = 1'b0;
    br_target = 16'h0; inst_ready = 1'b0;

    cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("l_rst_req", {15'd0, imem_req}, 16'h0);
    chk("l_rst_addr", imem_addr, 16'h0000);
    chk("l_rst_iv", {15'd0, inst_valid}, 16'h0);
    chk("l_rst_inst", inst, 16'h0000);
    chk("l_rst_pc", pc, 16'h0000);
    chk("l_rst_pc2", pc_plus2, 16'h0002);
    chk("l_rst_hlt", {15'd0, hlt}, 16'h0);

    idle_cyc();
    chk("l_fetch0_req", {15'd0, imem_req}, 16'h1);
    chk("l_fetch0_addr", imem_addr, 16'h0000);
    idle_cyc();
    cyc(1'b1, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
    chk("l_hold_iv", {15'd0, inst_valid}, 16'h1);
    chk("l_hold_inst", inst, 16'h1234);
    chk("l_hold_pc", pc, 16'h0000);
    chk("l_hold_pc2", pc_plus2, 16'h0002);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("l_next_addr", imem_addr, 16'h0002);
    chk("l_next_req", {15'd0, imem_req}, 16'h1);

    cyc(1'b1, 1'b1, 16'h1111, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("l_addr4", imem_addr, 16'h0004);
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0041, 1'b0);
    chk("l_sq_addr", imem_addr, 16'h0004);
    chk("l_sq_req", {15'd0, imem_req}, 16'h1);
    idle_cyc();
    chk("l_sq_hold_addr", imem_addr, 16'h0004);
    cyc(1'b1, 1'b1, 16'h5555, 1'b0, 16'h0, 1'b0);
    chk("l_redir_addr", imem_addr, 16'h0040);
    chk("l_redir_iv", {15'd0, inst_valid}, 16'h0);

    cyc(1'b1, 1'b1, 16'hAAAA, 1'b1, 16'h0009, 1'b0);
    chk("l_brv_addr", imem_addr, 16'h0008);
    chk("l_brv_iv", {15'd0, inst_valid}, 16'h0);
    cyc(1'b1, 1'b1, 16'h3333, 1'b0, 16'h0, 1'b0);
    chk("l_pc8", pc, 16'h0008);
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0100, 1'b1);
    chk("l_brwin_addr", imem_addr, 16'h0100);
    chk("l_brwin_iv", {15'd0, inst_valid}, 16'h0);

    cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0200, 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0301, 1'b0);
    cyc(1'b1, 1'b1, 16'hDDDD, 1'b1, 16'h0401, 1'b0);
    chk("l_latest_addr", imem_addr, 16'h0400);

    cyc(1'b1, 1'b1, 16'hBBBB, 1'b1, 16'hFFFF, 1'b0);
    chk("l_ffe_addr", imem_addr, 16'hFFFE);
    cyc(1'b1, 1'b1, 16'h4444, 1'b0, 16'h0, 1'b0);
    chk("l_wrap_pc", pc, 16'hFFFE);
    chk("l_wrap_pc2", pc_plus2, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("l_wrap_addr", imem_addr, 16'h0000);

    cyc(1'b1, 1'b1, 16'h6666, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b1, 16'h7777, 1'b0, 16'h0, 1'b0);
    chk("l_ign_inst", inst, 16'h6666);
    chk("l_ign_iv", {15'd0, inst_valid}, 16'h1);
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0010, 1'b0);
    chk("l_br_only_addr", imem_addr, 16'h0010);

    cyc(1'b1, 1'b1, 16'hF000, 1'b0, 16'h0, 1'b0);
    chk("l_halt_hlt", {15'd0, hlt}, 16'h1);
    chk("l_halt_pc", pc, 16'h0010);
    chk("l_halt_iv", {15'd0, inst_valid}, 16'h0);
    chk("l_halt_req", {15'd0, imem_req}, 16'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'h1234, 1'b1, 16'h0050, 1'b1);
    chk("l_halt_stay_hlt", {15'd0, hlt}, 16'h1);
    chk("l_halt_stay_req", {15'd0, imem_req}, 16'h0);
    chk("l_halt_stay_pc", pc, 16'h0010);

    cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("l_rst2_hlt", {15'd0, hlt}, 16'h0);
    chk("l_rst2_req", {15'd0, imem_req}, 16'h0);
    chk("l_rst2_pc", pc, 16'h0000);
    idle_cyc();
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0020, 1'b0);
    cyc(1'b0, 1'b1, 16'hCCCC, 1'b0, 16'h0, 1'b0);
    chk("l_sqrst_req", {15'd0, imem_req}, 16'h0);
    cyc(1'b1, 1'b1, 16'h8888, 1'b0, 16'h0, 1'b0);
    chk("l_sqrst_addr", imem_addr, 16'h0000);
    chk("l_sqrst_hlt", {15'd0, hlt}, 16'h0);
    chk("l_sqrst_iv", {15'd0, inst_valid}, 16'h0);
    chk("l_sqrst_req2", {15'd0, imem_req}, 16'h1);
    cyc(1'b1, 1'b1, 16'h9999, 1'b0, 16'h0, 1'b0);
    chk("l_after_inst", inst, 16'h9999);
    chk("l_after_pc", pc, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    idle_cyc();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
